// File: rtl/sa_ram_rd_stream.sv
// Burst read controller for a two-port RAM with a registered read address and an output register.
// Reads pass through a 2-stage pipeline into a credit-protected FWFT FIFO that drives a valid/ready stream.
module sa_ram_rd_stream #(
    parameter int AW         = 4,
    parameter int DW         = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_len,
    output logic [AW-1:0] ram_ra,
    output logic          ram_re,
    output logic          ram_ore,
    input  logic [DW-1:0] ram_dout,
    output logic [31:0]   ram_pwrbus_pd,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [DW-1:0] dout_data,
    output logic          dout_last
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state, state_next;
    logic [AW-1:0] addr, remaining;
    logic          s1, s2, s1_last, s2_last;
    logic          issue, accept, push, pop, last_hs;
    logic [CW:0]   credit_used;

    logic [DW-1:0] fifo_data [FIFO_DEPTH];
    logic          fifo_last [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    // Reads in flight (s1, s2) count against FIFO space so a push always finds room.
    assign credit_used = {1'b0, count} + (CW+1)'(s1) + (CW+1)'(s2);
    assign issue       = (state == RUN) && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign accept      = cmd_valid && cmd_ready;
    assign push        = s2;
    assign pop         = dout_valid && dout_ready;
    assign last_hs     = pop && dout_last;

    assign ram_ra        = addr;
    assign ram_re        = issue;
    assign ram_ore       = s1;
    assign ram_pwrbus_pd = 32'b0;

    assign dout_valid = (count != '0);
    assign dout_data  = dout_valid ? fifo_data[rd_ptr] : '0;
    assign dout_last  = dout_valid ? fifo_last[rd_ptr] : 1'b0;

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_next = RUN;
            end
            RUN: begin
                if (issue && (remaining == '0)) state_next = DRAIN;
            end
            DRAIN: begin
                if (last_hs) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            s1        <= 1'b0;
            s2        <= 1'b0;
            s1_last   <= 1'b0;
            s2_last   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr      <= cmd_addr;
                remaining <= cmd_len;
            end else if (issue) begin
                addr      <= addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            s1      <= issue;
            s1_last <= issue && (remaining == '0);
            s2      <= s1;
            s2_last <= s1_last;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= ram_dout;
            fifo_last[wr_ptr] <= s2_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_sa_ram_rd_stream.sv
// Bench for sa_ram_rd_stream: RAM model plus a burst-level expected-beat queue checked every cycle,
// with directed latency/backpressure/reset scenarios and randomized bursts.
module tb_sa_ram_rd_stream;

    localparam int AW = 4;
    localparam int DW = 256;
    localparam int FIFO_DEPTH = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [AW-1:0] cmd_len = '0;
    logic [AW-1:0] ram_ra;
    logic          ram_re;
    logic          ram_ore;
    logic [DW-1:0] ram_dout;
    logic [31:0]   ram_pwrbus_pd;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
    logic [DW-1:0] dout_data;
    logic          dout_last;

    sa_ram_rd_stream #(.AW(AW), .DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .ram_ra(ram_ra), .ram_re(ram_re), .ram_ore(ram_ore), .ram_dout(ram_dout),
        .ram_pwrbus_pd(ram_pwrbus_pd),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data), .dout_last(dout_last)
    );

    always #5 clk = ~clk;

    // RAM: address captured on re, data registered on ore.
    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] ra_q;
    always @(posedge clk) begin
        if (ram_re)  ra_q     <= ram_ra;
        if (ram_ore) ram_dout <= mem[ra_q];
    end

    int compared = 0;
    int mismatched = 0;

    task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Burst-level reference model: beats owed to the sink, reads still to issue.
    beat_t         q[$];
    logic          busy = 1'b0;
    int            issues_left = 0;
    int            outstanding = 0;
    logic [AW-1:0] exp_ra = '0;
    logic          re_prev = 1'b0;
    int            cyc = 0;
    int            re_total = 0;
    int            accepts = 0;
    int            last_hs_cyc = -100;
    int            gap_at_accept = 0;
    logic          chk_en = 1'b0;

    always @(posedge clk) begin
        logic busy_pre;
        cyc++;
        if (rst) begin
            q.delete();
            busy = 1'b0;
            issues_left = 0;
            outstanding = 0;
            re_prev = 1'b0;
        end else begin
            busy_pre = busy;
            if (dout_valid && dout_ready) begin
                outstanding--;
                if (q.size() != 0) begin
                    if (q[0].last) begin
                        busy = 1'b0;
                        last_hs_cyc = cyc;
                    end
                    void'(q.pop_front());
                end
            end
            if (ram_re) begin
                outstanding++;
                re_total++;
                issues_left--;
                exp_ra = exp_ra + 1'b1;
            end
            re_prev = ram_re;
            if (cmd_valid && !busy_pre) begin
                for (int i = 0; i <= int'(cmd_len); i++) begin
                    beat_t b;
                    b.data = mem[AW'(int'(cmd_addr) + i)];
                    b.last = (i == int'(cmd_len));
                    q.push_back(b);
                end
                busy = 1'b1;
                issues_left = int'(cmd_len) + 1;
                exp_ra = cmd_addr;
                accepts++;
                gap_at_accept = cyc - last_hs_cyc;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            cmp("cmd_ready", cmd_ready, !busy);
            cmp("ore_follows_re", ram_ore, re_prev);
            cmp("credit_bound", outstanding <= FIFO_DEPTH, 1'b1);
            if (dout_valid) begin
                cmp("valid_has_beat", q.size() != 0, 1'b1);
                if (q.size() != 0) begin
                    cmp("dout_data", dout_data, q[0].data);
                    cmp("dout_last", dout_last, q[0].last);
                end
            end
            if (ram_re) begin
                cmp("re_allowed", issues_left > 0, 1'b1);
                cmp("ram_ra", ram_ra, exp_ra);
            end
        end
    end

    // Sink readiness: 0 always ready, 1 one-on/three-off, 2 never, 3 random.
    int mode = 0;
    int ph = 0;
    always @(posedge clk) begin
        #1;
        ph = (ph + 1) % 4;
        case (mode)
            0:       dout_ready = 1'b1;
            1:       dout_ready = (ph == 0);
            2:       dout_ready = 1'b0;
            default: dout_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [AW-1:0] a, input logic [AW-1:0] l);
        step();
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        step();
        cmd_valid = 1'b0;
        cmd_addr  = AW'($urandom);
        cmd_len   = AW'($urandom);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        cmp("idle_timeout", busy, 1'b0);
        cmp("queue_drained", q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        cmp({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        cmp({tag, "_ram_re"}, ram_re, 1'b0);
        cmp({tag, "_ram_ore"}, ram_ore, 1'b0);
        cmp({tag, "_ram_ra"}, ram_ra, 0);
        cmp({tag, "_dout_valid"}, dout_valid, 1'b0);
        cmp({tag, "_dout_last"}, dout_last, 1'b0);
        cmp({tag, "_dout_data"}, dout_data, 0);
        cmp({tag, "_pwrbus"}, ram_pwrbus_pd, 0);
    endtask

    // Observes the 30 cycles following an acceptance edge (cycle index 1 = first cycle after it).
    task automatic measure(output int re_cnt, output int last_re, output int first_valid,
                           output int first_rdy, output logic [DW-1:0] first_data,
                           output logic first_last);
        re_cnt = 0; last_re = 0; first_valid = 0; first_rdy = 0;
        first_data = '0; first_last = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (ram_re) begin
                re_cnt++;
                last_re = k;
            end
            if (dout_valid && first_valid == 0) begin
                first_valid = k;
                first_data  = dout_data;
                first_last  = dout_last;
            end
            if (cmd_ready && first_rdy == 0) first_rdy = k;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int re_cnt, last_re, first_valid, first_rdy, re_base, acc_base, n;
        logic [DW-1:0] fdata;
        logic flast;

        for (int k = 0; k < 2**AW; k++) mem[k] = {32{8'(k * 17)}};

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        chk_en = 1'b1;

        // Single beat from address 5.
        mode = 0;
        send_cmd(4'd5, 4'd0);
        measure(re_cnt, last_re, first_valid, first_rdy, fdata, flast);
        cmp("b1_re_count", re_cnt, 1);
        cmp("b1_first_valid_cycle", first_valid, 4);
        cmp("b1_data", fdata, {32{8'h55}});
        cmp("b1_last", flast, 1'b1);
        cmp("b1_ready_return_cycle", first_rdy, 5);

        // Full-RAM burst wrapping 15 -> 0, sink always ready.
        send_cmd(4'd12, 4'd15);
        measure(re_cnt, last_re, first_valid, first_rdy, fdata, flast);
        cmp("b16_re_count", re_cnt, 16);
        cmp("b16_re_contiguous", last_re, 16);
        cmp("b16_first_data", fdata, {32{8'hCC}});
        cmp("b16_first_last", flast, 1'b0);
        cmp("b16_done_cycle", first_rdy, 20);

        // Same burst with a 1-on/3-off sink.
        mode = 1;
        send_cmd(4'd12, 4'd15);
        wait_idle(400);

        // Sink stalled for the whole burst: only FIFO_DEPTH reads may be issued.
        mode = 2;
        re_base = re_total;
        send_cmd(4'd0, 4'd15);
        repeat (25) @(negedge clk);
        cmp("stall_reads_issued", re_total - re_base, 4);
        cmp("stall_re_low", ram_re, 1'b0);
        mode = 0;
        wait_idle(200);

        // Reset three cycles into an 8-beat burst.
        send_cmd(4'd3, 4'd7);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        repeat (8) @(negedge clk);
        cmp("midreset_no_residual", dout_valid, 1'b0);
        send_cmd(4'd14, 4'd3);
        wait_idle(200);

        // cmd_valid held high: second burst only the cycle after the first last handshake.
        acc_base = accepts;
        step();
        cmd_addr  = 4'd9;
        cmd_len   = 4'd2;
        cmd_valid = 1'b1;
        n = 0;
        while (accepts < acc_base + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b0;
        cmp("b2b_both_accepted", accepts - acc_base, 2);
        cmp("b2b_gap", gap_at_accept, 1);
        wait_idle(200);

        // Randomized bursts with a random sink.
        mode = 3;
        for (int b = 0; b < 25; b++) begin
            repeat ($urandom_range(0, 3)) step();
            send_cmd(AW'($urandom), AW'($urandom));
            wait_idle(400);
        end
        mode = 0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
